// File: rtl/ciscud_captador.sv
// -----------------------------------------------------------------------------
// ciscud_captador -- instruction fetch stage of the CiscUd core.
//
// Reads variable-length instructions (1..4 bytes, length encoded in
// opcode[7:6]) one byte per memory handshake and hands each complete
// instruction, left-aligned with the opcode in [31:24], to the decoder.
// A redirect from execute may arrive at any time; it never abandons a read
// the memory has not acknowledged yet, so it is parked until that read ends.
//
// Ports
//   Reloj        clock, rising edge
//   Reiniciar    asynchronous active-low reset
//   MemDir       byte address of the current read (the PC)
//   MemLeer      read request, high while fetching
//   MemDato      read data, sampled when MemLeer & MemListo
//   MemListo     memory acknowledge for the current read
//   Instr        assembled instruction, unused low bytes zero
//   InstrLong    instruction length in bytes (1..4)
//   InstrPC      address of the opcode byte
//   InstrValida  Instr/InstrLong/InstrPC valid
//   InstrTomada  decoder accepts the presented instruction
//   Salto        redirect request (one-cycle pulse)
//   DirSalto     redirect target
// -----------------------------------------------------------------------------
module ciscud_captador #(
  parameter int                   ANCHO_DIR  = 8,
  parameter logic [ANCHO_DIR-1:0] PC_INICIAL = '0
) (
  input  logic                 Reloj,
  input  logic                 Reiniciar,
  output logic [ANCHO_DIR-1:0] MemDir,
  output logic                 MemLeer,
  input  logic [7:0]           MemDato,
  input  logic                 MemListo,
  output logic [31:0]          Instr,
  output logic [2:0]           InstrLong,
  output logic [ANCHO_DIR-1:0] InstrPC,
  output logic                 InstrValida,
  input  logic                 InstrTomada,
  input  logic                 Salto,
  input  logic [ANCHO_DIR-1:0] DirSalto
);

  typedef enum logic [1:0] {
    PEDIR_OP  = 2'd0,
    PEDIR_OPR = 2'd1,
    ENTREGA   = 2'd2
  } estado_t;

  estado_t              r_estado;
  estado_t              w_estado_sig;
  logic [ANCHO_DIR-1:0] r_pc;
  logic [31:0]          r_instr;
  logic [2:0]           r_long;
  logic [ANCHO_DIR-1:0] r_instr_pc;
  logic [2:0]           r_cuenta;
  logic                 r_pend;
  logic [ANCHO_DIR-1:0] r_dir_pend;

  logic                 w_captura;
  logic                 w_redir;
  logic [ANCHO_DIR-1:0] w_dir_redir;
  logic                 w_fin_opr;
  logic [ANCHO_DIR-1:0] w_pc_mas1;

  // Instruction length from the two top opcode bits: 00->1 .. 11->4.
  function automatic logic [2:0] long_de_op(input logic [7:0] op);
    return {1'b0, op[7:6]} + 3'd1;
  endfunction

  assign w_pc_mas1   = r_pc + {{(ANCHO_DIR-1){1'b0}}, 1'b1};
  assign w_captura   = MemLeer & MemListo;
  // A fresh Salto wins over a parked one (it overwrites the latched target).
  assign w_dir_redir = Salto ? DirSalto : r_dir_pend;
  // Redirect takes effect immediately in ENTREGA, otherwise only on the edge
  // that completes the outstanding read (whose byte is then dropped).
  assign w_redir     = ((r_estado == ENTREGA) & Salto) | (w_captura & (Salto | r_pend));
  assign w_fin_opr   = (3'(r_cuenta + 3'd1) == r_long);

  assign MemDir    = r_pc;
  assign Instr     = r_instr;
  assign InstrLong = r_long;
  assign InstrPC   = r_instr_pc;

  // --- state register ---
  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      r_estado <= PEDIR_OP;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // --- next state and state-decoded outputs ---
  always_comb begin
    w_estado_sig = r_estado;
    MemLeer      = 1'b0;
    InstrValida  = 1'b0;
    case (r_estado)
      PEDIR_OP: begin
        MemLeer = 1'b1;
        if (MemListo) begin
          if (Salto | r_pend)                w_estado_sig = PEDIR_OP;
          else if (long_de_op(MemDato) == 3'd1) w_estado_sig = ENTREGA;
          else                               w_estado_sig = PEDIR_OPR;
        end
      end
      PEDIR_OPR: begin
        MemLeer = 1'b1;
        if (MemListo) begin
          if (Salto | r_pend) w_estado_sig = PEDIR_OP;
          else if (w_fin_opr) w_estado_sig = ENTREGA;
        end
      end
      ENTREGA: begin
        InstrValida = 1'b1;
        // Salto together with InstrTomada: the instruction is consumed and
        // the redirect still applies; both lead back to PEDIR_OP.
        if (Salto | InstrTomada) w_estado_sig = PEDIR_OP;
      end
      default: w_estado_sig = PEDIR_OP;
    endcase
  end

  // --- PC, pending redirect and instruction assembly ---
  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      r_pc       <= PC_INICIAL;
      r_instr    <= 32'h0;
      r_long     <= 3'd0;
      r_instr_pc <= '0;
      r_cuenta   <= 3'd0;
      r_pend     <= 1'b0;
      r_dir_pend <= '0;
    end else if (w_redir) begin
      r_pc   <= w_dir_redir;
      r_pend <= 1'b0;
    end else if (MemLeer && Salto) begin
      // Read still unacknowledged: park the target until it completes.
      r_pend     <= 1'b1;
      r_dir_pend <= DirSalto;
    end else if (w_captura) begin
      r_pc <= w_pc_mas1;
      if (r_estado == PEDIR_OP) begin
        r_instr    <= {MemDato, 24'h0};
        r_instr_pc <= r_pc;
        r_long     <= long_de_op(MemDato);
        r_cuenta   <= 3'd1;
      end else begin
        case (r_cuenta)
          3'd1:    r_instr[23:16] <= MemDato;
          3'd2:    r_instr[15:8]  <= MemDato;
          3'd3:    r_instr[7:0]   <= MemDato;
          default: r_instr        <= r_instr;
        endcase
        r_cuenta <= r_cuenta + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ciscud_captador.sv
module tb_ciscud_captador;

  typedef struct packed {
    logic [31:0] i;
    logic [2:0]  l;
    logic [7:0]  p;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem  [256];
  logic [7:0]  mem2 [256];

  logic [7:0]  MemDir;
  logic        MemLeer;
  logic [7:0]  MemDato;
  logic        MemListo;
  logic [31:0] Instr;
  logic [2:0]  InstrLong;
  logic [7:0]  InstrPC;
  logic        InstrValida;
  logic        InstrTomada;
  logic        Salto;
  logic [7:0]  DirSalto;

  logic [7:0]  d2_dir;
  logic        d2_leer;
  logic [7:0]  d2_dato;
  logic [31:0] d2_instr;
  logic [2:0]  d2_long;
  logic [7:0]  d2_pc;
  logic        d2_valid;
  logic        d2_tomada;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  assign MemDato = mem[MemDir];
  assign d2_dato = mem2[d2_dir];

  ciscud_captador #(.ANCHO_DIR(8), .PC_INICIAL(8'h00)) dut (
    .Reloj(clk), .Reiniciar(rst_n),
    .MemDir(MemDir), .MemLeer(MemLeer), .MemDato(MemDato), .MemListo(MemListo),
    .Instr(Instr), .InstrLong(InstrLong), .InstrPC(InstrPC),
    .InstrValida(InstrValida), .InstrTomada(InstrTomada),
    .Salto(Salto), .DirSalto(DirSalto)
  );

  ciscud_captador #(.ANCHO_DIR(8), .PC_INICIAL(8'hFE)) dut2 (
    .Reloj(clk), .Reiniciar(rst_n),
    .MemDir(d2_dir), .MemLeer(d2_leer), .MemDato(d2_dato), .MemListo(1'b1),
    .Instr(d2_instr), .InstrLong(d2_long), .InstrPC(d2_pc),
    .InstrValida(d2_valid), .InstrTomada(d2_tomada),
    .Salto(1'b0), .DirSalto(8'h00)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference model: walk the memory image from pc0 and queue the next n
  // instructions exactly as the decoder should receive them.
  task automatic push_walk(input logic [7:0] pc0, input int n);
    logic [7:0]  pc;
    logic [31:0] ins;
    int          len;
    exp_t        e;
    pc = pc0;
    for (int k = 0; k < n; k++) begin
      len = int'(mem[pc][7:6]) + 1;
      ins = 32'h0;
      for (int b = 0; b < len; b++) ins[31-8*b -: 8] = mem[pc + 8'(b)];
      e.i = ins;
      e.l = 3'(len);
      e.p = pc;
      q.push_back(e);
      pc = pc + 8'(len);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted instruction and watches
  // that the read address holds while a read is waiting for memory.
  initial begin : monitor
    logic       prev_hold;
    logic [7:0] prev_dir;
    exp_t       e;
    prev_hold = 1'b0;
    prev_dir  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("memdir_stable", 64'(MemDir), 64'(prev_dir));
        prev_hold = MemLeer && !MemListo;
        prev_dir  = MemDir;
        if (InstrValida && InstrTomada) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_instr: got %0h/%0d/%0h, expected none",
                     Instr, InstrLong, InstrPC);
          end else begin
            e = q.pop_front();
            chk("instr", {InstrValida, Instr, InstrLong, InstrPC}, {1'b1, e.i, e.l, e.p});
          end
        end
      end
    end
  end

  task automatic load_image();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h05; mem[1] = 8'h4A; mem[2] = 8'h33; mem[3] = 8'hC1;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    Salto       = 1'b0;
    DirSalto    = 8'h00;
    MemListo    = 1'b1;
    InstrTomada = 1'b0;
    d2_tomada   = 1'b0;
    q.delete();
    @(posedge clk); #1;
    chk("reset_outputs", {InstrValida, Instr, InstrLong, InstrPC}, 64'h0);
    chk("reset_memport", {MemLeer, MemDir}, {1'b1, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_inputs(input int c, input int lmode, input int tmode);
    case (lmode)
      0:       MemListo = 1'b1;
      1:       MemListo = (c % 3 == 0);
      default: MemListo = 1'($urandom_range(0, 1));
    endcase
    InstrTomada = (q.size() > 0) && (tmode == 0 || $urandom_range(0, 1) == 1);
  endtask

  // Run until every queued instruction has been accepted; the decoder only
  // accepts while something is still expected.
  task automatic run_until_drained(input int lmode, input int tmode, input int budget);
    int c;
    c = 0;
    set_inputs(c, lmode, tmode);
    while (q.size() > 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      set_inputs(c, lmode, tmode);
    end
    InstrTomada = 1'b0;
    MemListo    = 1'b1;
    chk("drain_remaining", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int c;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 256; i++) mem2[i] = 8'h00;
    mem2[8'hFE] = 8'h80; mem2[8'hFF] = 8'hAA; mem2[8'h00] = 8'hBB;

    // Basic stream, ready memory, eager decoder.
    load_image();
    do_reset();
    push_walk(8'h00, 3);
    MemListo    = 1'b1;
    InstrTomada = 1'b1;
    @(posedge clk); #1;
    chk("first_valid", {InstrValida, Instr}, {1'b1, 32'h05000000});
    run_until_drained(0, 0, 50);

    // Backpressure while 4A330000 is presented.
    do_reset();
    push_walk(8'h00, 3);
    InstrTomada = 1'b1;
    c = 0;
    while (!(InstrValida && Instr == 32'h4A330000) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    InstrTomada = 1'b0;
    chk("bp_reached", 64'(InstrValida && Instr == 32'h4A330000), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_frozen", {InstrValida, MemLeer, Instr, InstrLong, InstrPC},
          {1'b1, 1'b0, 32'h4A330000, 3'd2, 8'h01});
    end
    InstrTomada = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_fetch", {MemLeer, MemDir}, {1'b1, 8'h03});
    run_until_drained(0, 0, 50);

    // Wait states: memory acknowledges every third cycle.
    do_reset();
    push_walk(8'h00, 3);
    run_until_drained(1, 0, 100);

    // Redirect while the read of address 4 is stalled.
    do_reset();
    push_walk(8'h00, 2);
    c = 0;
    InstrTomada = 1'b1;
    while (!(MemLeer && MemDir == 8'h04) && c < 30) begin
      @(posedge clk); #1;
      c++;
      InstrTomada = (q.size() > 0);
    end
    chk("redir_reached", {MemLeer, MemDir, 32'(q.size())}, {1'b1, 8'h04, 32'd0});
    MemListo = 1'b0;
    Salto    = 1'b1;
    DirSalto = 8'h00;
    @(posedge clk); #1;
    Salto    = 1'b0;
    MemListo = 1'b1;
    chk("redir_hold", {InstrValida, MemLeer, MemDir}, {1'b0, 1'b1, 8'h04});
    @(posedge clk); #1;
    chk("redir_target", {InstrValida, MemLeer, MemDir}, {1'b0, 1'b1, 8'h00});
    push_walk(8'h00, 2);
    run_until_drained(0, 0, 50);

    // Randomised images, random memory ready and random decoder acceptance.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      push_walk(8'h00, 10);
      run_until_drained(2, 2, 600);
    end

    // Address wrap on the second instance (PC_INICIAL = FE).
    load_image();
    do_reset();
    c = 0;
    while (!d2_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("wrap_instr", {d2_valid, d2_instr, d2_long, d2_pc}, {1'b1, 32'h80AABB00, 3'd3, 8'hFE});
    d2_tomada = 1'b1;
    @(posedge clk); #1;
    d2_tomada = 1'b0;
    chk("wrap_next_dir", {d2_leer, d2_dir}, {1'b1, 8'h01});

    // Asynchronous reset while an instruction is presented.
    do_reset();
    InstrTomada = 1'b0;
    c = 0;
    while (!InstrValida && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("async_pre", {InstrValida, Instr}, {1'b1, 32'h05000000});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_clear", {InstrValida, Instr, InstrLong, InstrPC}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async_restart", {MemLeer, MemDir}, {1'b1, 8'h00});
    @(posedge clk); #1;
    chk("async_refetch", {InstrValida, Instr, InstrPC}, {1'b1, 32'h05000000, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ciscud_captador.md
Name: ciscud_captador

Overview:
Instruction fetch stage of the CiscUd CISC core; sits directly downstream of the core's clock/reset source and upstream of the decoder. Reads variable-length instructions (1-4 bytes) one byte at a time from a byte-wide memory port using a request/ready handshake. Presents each complete instruction, left-aligned, to the decoder over a valid/taken handshake. Supports a redirect (jump) input from execute.

Parameters:
ANCHO_DIR, 8, memory/PC address width in bits
PC_INICIAL, 0, PC value loaded on reset

Ports:
Reloj  input  1  clock, rising edge
Reiniciar  input  1  reset, asynchronous, active-low
MemDir  output  ANCHO_DIR  byte address of current memory read
MemLeer  output  1  memory read request
MemDato  input  8  read data, valid when MemLeer&MemListo
MemListo  input  1  memory ready/ack for current read
Instr  output  32  assembled instruction, opcode in [31:24], unused bytes zero
InstrLong  output  3  instruction length in bytes, 1..4
InstrPC  output  ANCHO_DIR  address of the opcode byte
InstrValida  output  1  Instr/InstrLong/InstrPC valid
InstrTomada  input  1  decoder accepts instruction
Salto  input  1  redirect request, one-cycle pulse
DirSalto  input  ANCHO_DIR  redirect target

Behaviour:
- Reset (Reiniciar=0, async): PC=PC_INICIAL, state=PEDIR_OP, Instr=0, InstrLong=0, InstrPC=0, InstrValida=0, redirect-pending flag=0. MemLeer is decoded from state, so it is 1 during reset with MemDir=PC_INICIAL; memory must ignore it while reset is asserted.
- Length decode from opcode[7:6]: 00->1, 01->2, 10->3, 11->4.
- States: PEDIR_OP, PEDIR_OPR, ENTREGA.
- MemLeer=1 in PEDIR_OP/PEDIR_OPR, 0 in ENTREGA. MemDir=PC, stable while MemLeer=1 and MemListo=0. MemListo is ignored when MemLeer=0.
- PEDIR_OP, edge with MemListo=1: Instr<={MemDato,24'h0}, InstrPC<=PC, InstrLong<=decoded length, byte count<=1, PC<=PC+1. If length=1 go to ENTREGA, else go to PEDIR_OPR.
- PEDIR_OPR, edge with MemListo=1: write MemDato into byte slot count (slot 1=[23:16], 2=[15:8], 3=[7:0]), count++, PC<=PC+1. Go to ENTREGA when count reaches length.
- ENTREGA: InstrValida=1; all Instr* outputs held stable. Edge with InstrTomada=1 -> InstrValida<=0, go to PEDIR_OP. No prefetch.
- Latency with MemListo tied 1: an n-byte instruction takes n capture edges, and InstrValida rises on the n-th capture edge. Throughput is n+1 cycles per instruction with InstrTomada=1.
- PC arithmetic is modulo 2^ANCHO_DIR. An instruction spanning the wrap continues fetching at address 0.
- Salto has priority over everything except an unfinished memory handshake:
  - In ENTREGA, or in a PEDIR state on an edge with MemListo=1: PC<=DirSalto, state<=PEDIR_OP, InstrValida<=0. Any partial instruction or captured byte is discarded.
  - In a PEDIR state with MemListo=0: set the pending flag and latch DirSalto. The outstanding read completes, its byte is discarded, then the redirect is applied as above.
  - A second Salto while pending overwrites the latched target.
- Salto and InstrTomada on the same ENTREGA edge: the instruction counts as consumed and the redirect applies.
- Reset mid-operation: all state and outputs clear immediately and asynchronously. Fetch restarts at PC_INICIAL after release.

Test Plan:
- Memory image: [0]=05, [1]=4A, [2]=33, [3]=C1, [4]=11, [5]=22, [6]=33. MemListo=1, InstrTomada=1. Required: {Instr, InstrLong, InstrPC} = {05000000, 1, 0}, then {4A330000, 2, 1}, then {C1112233, 4, 3}. First InstrValida rises on the first edge after reset release.
- Backpressure: same image, InstrTomada=0 for 5 cycles while 4A330000 is valid. Required: outputs frozen, MemLeer=0 throughout. Next opcode fetch starts at MemDir=3 after InstrTomada=1.
- Wait states: MemListo=1 only every 3rd cycle. Required: same three instructions, and MemDir never changes while MemLeer=1 and MemListo=0.
- Redirect mid-read: Salto with DirSalto=0x00 during the PEDIR_OPR read of address 4, with MemListo=0. Required: byte 0x11 discarded, no instruction delivered, next MemDir=0, next instruction 05000000.
- Wrap: PC_INICIAL=0xFE, [FE]=80, [FF]=AA, [00]=BB. Required: Instr=80AABB00, InstrLong=3, InstrPC=FE, next MemDir=01.
- Async reset while InstrValida=1. Required: InstrValida, Instr, InstrLong and InstrPC go to 0 without waiting for a clock edge. After release, first MemDir=PC_INICIAL.
